// File: rtl/uart_mem_loader_pkg.sv
// Shared types for the UART memory loader: frame FSM states, sync byte and address stepping.
package uart_mem_loader_pkg;

  typedef enum logic [2:0] {
    LDR_IDLE,
    LDR_ADDR,
    LDR_CNT,
    LDR_DATA,
    LDR_WRITE,
    LDR_CHK
  } loader_state_e;

  localparam logic [7:0] LOADER_SYNC = 8'hA5;

  // Next word address; low two bits are always dropped so the bus only sees aligned words.
  function automatic logic [31:0] next_word_addr(input logic [31:0] addr);
    return {addr[31:2] + 30'd1, 2'b00};
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: 2-FF synchroniser, start-bit qualification at half a bit, mid-bit sampling.
// valid_o pulses once per byte at the stop bit; frame_err_o accompanies it when the stop bit is 0.
module uart_rx_byte #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       valid_o,
  output logic       frame_err_o
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  logic [1:0]    r_sync;
  logic          r_active;
  logic [3:0]    r_bit_cnt;
  logic [CW-1:0] r_clk_cnt;
  logic [7:0]    r_shift;
  logic          r_valid;
  logic          r_ferr;
  logic          w_rx;

  assign w_rx = r_sync[1];

  // r_bit_cnt: 0 = start bit, 1..8 = data bits, 9 = stop bit.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sync    <= 2'b11;
      r_active  <= 1'b0;
      r_bit_cnt <= 4'd0;
      r_clk_cnt <= '0;
      r_shift   <= 8'd0;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], rx_i};
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      if (!r_active) begin
        if (!w_rx) begin
          r_active  <= 1'b1;
          r_clk_cnt <= '0;
          r_bit_cnt <= 4'd0;
        end
      end else if (r_bit_cnt == 4'd0) begin
        if (r_clk_cnt == HALF_LAST) begin
          r_clk_cnt <= '0;
          if (w_rx) r_active <= 1'b0;
          else      r_bit_cnt <= 4'd1;
        end else begin
          r_clk_cnt <= r_clk_cnt + 1'b1;
        end
      end else if (r_clk_cnt == FULL_LAST) begin
        r_clk_cnt <= '0;
        if (r_bit_cnt == 4'd9) begin
          r_active <= 1'b0;
          r_valid  <= 1'b1;
          r_ferr   <= !w_rx;
        end else begin
          r_shift   <= {w_rx, r_shift[7:1]};
          r_bit_cnt <= r_bit_cnt + 4'd1;
        end
      end else begin
        r_clk_cnt <= r_clk_cnt + 1'b1;
      end
    end
  end

  assign byte_o      = r_shift;
  assign valid_o     = r_valid;
  assign frame_err_o = r_ferr;

endmodule

// File: rtl/uart_mem_loader.sv
// UART-driven loader: parses A5|addr|count|data frames, writes words to memory while holding the core
// in reset. Optional trailing checksum byte is enabled by defining LOADER_CHECKSUM_EN.
module uart_mem_loader
  import uart_mem_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT   = 868,
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000,
  parameter logic        HOLD_AT_RESET  = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rx_i,
  output logic        mem_operation_enable_o,
  output logic [3:0]  mem_write_enable_o,
  output logic [31:0] mem_address_o,
  output logic [31:0] mem_data_o,
  output logic        busy_o,
  output logic        sys_reset_o,
  output logic        error_o,
  output logic [2:0]  dbg_state_o
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

`ifdef LOADER_CHECKSUM_EN
  localparam logic CHK_EN = 1'b1;
`else
  localparam logic CHK_EN = 1'b0;
`endif
  localparam loader_state_e END_STATE = CHK_EN ? LDR_CHK : LDR_IDLE;

  loader_state_e r_state, w_next;
  logic [7:0]    w_byte;
  logic          w_valid, w_ferr, w_byte_ok, w_timeout, w_err, w_last_word, w_chk_ok;
  logic [15:0]   w_cnt_full;
  logic [1:0]    r_byte_cnt;
  logic [31:0]   r_addr, r_word;
  logic [15:0]   r_count, r_words;
  logic [TW-1:0] r_to_cnt;
  logic          r_busy, r_sys_reset, r_error;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk        (clk),
    .reset_n    (reset_n),
    .rx_i       (rx_i),
    .byte_o     (w_byte),
    .valid_o    (w_valid),
    .frame_err_o(w_ferr)
  );

  assign w_byte_ok   = w_valid && !w_ferr;
  assign w_timeout   = (r_to_cnt == TO_LAST);
  assign w_last_word = (r_words + 16'd1) == r_count;
  assign w_cnt_full  = {w_byte, r_count[15:8]};

`ifdef LOADER_CHECKSUM_EN
  // Running sum over addr/count/data; a correct trailing byte brings it to zero.
  logic [7:0] r_sum;
  assign w_chk_ok = (r_sum + w_byte) == 8'h00;
  always_ff @(posedge clk) begin
    if (!reset_n || r_state == LDR_IDLE) r_sum <= 8'h00;
    else if (w_byte_ok && (r_state inside {LDR_ADDR, LDR_CNT, LDR_DATA})) r_sum <= r_sum + w_byte;
  end
`else
  assign w_chk_ok = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= LDR_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next                 = r_state;
    w_err                  = 1'b0;
    mem_operation_enable_o = 1'b0;
    mem_write_enable_o     = 4'h0;
    mem_address_o          = 32'd0;
    mem_data_o             = 32'd0;
    case (r_state)
      LDR_IDLE: if (w_byte_ok && w_byte == LOADER_SYNC) w_next = LDR_ADDR;
      LDR_ADDR: if (w_byte_ok && r_byte_cnt == 2'd3) w_next = LDR_CNT;
      LDR_CNT:  if (w_byte_ok && r_byte_cnt == 2'd1) w_next = (w_cnt_full == 16'd0) ? END_STATE : LDR_DATA;
      LDR_DATA: if (w_byte_ok && r_byte_cnt == 2'd3) w_next = LDR_WRITE;
      LDR_WRITE: begin
        w_next                 = w_last_word ? END_STATE : LDR_DATA;
        mem_operation_enable_o = 1'b1;
        mem_write_enable_o     = 4'hF;
        mem_address_o          = {r_addr[31:2], 2'b00};
        mem_data_o             = r_word;
      end
      LDR_CHK: if (w_byte_ok) begin
        if (w_chk_ok) w_next = LDR_IDLE;
        else          w_err  = 1'b1;
      end
      default: w_next = LDR_IDLE;
    endcase
    if (r_state != LDR_IDLE && ((w_valid && w_ferr) || w_timeout)) w_err = 1'b1;
    if (w_err) w_next = LDR_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_byte_cnt  <= 2'd0;
      r_addr      <= 32'd0;
      r_word      <= 32'd0;
      r_count     <= 16'd0;
      r_words     <= 16'd0;
      r_to_cnt    <= '0;
      r_busy      <= 1'b0;
      r_sys_reset <= HOLD_AT_RESET;
      r_error     <= 1'b0;
    end else begin
      r_to_cnt <= (r_state == LDR_IDLE || w_valid) ? '0 : r_to_cnt + 1'b1;
      if (w_err) begin
        r_error <= 1'b1;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          LDR_IDLE: if (w_next == LDR_ADDR) begin
            r_error    <= 1'b0;
            r_byte_cnt <= 2'd0;
            r_words    <= 16'd0;
          end
          LDR_ADDR: if (w_byte_ok) begin
            r_addr     <= {w_byte, r_addr[31:8]};
            r_byte_cnt <= r_byte_cnt + 2'd1;
          end
          LDR_CNT: if (w_byte_ok) begin
            r_count    <= w_cnt_full;
            r_byte_cnt <= (r_byte_cnt == 2'd1) ? 2'd0 : 2'd1;
            if (r_byte_cnt == 2'd1) begin
              if (w_cnt_full != 16'd0) begin
                r_busy      <= 1'b1;
                r_sys_reset <= 1'b1;
              end else if (!CHK_EN) begin
                r_sys_reset <= 1'b0;
              end
            end
          end
          LDR_DATA: if (w_byte_ok) begin
            r_word     <= {w_byte, r_word[31:8]};
            r_byte_cnt <= r_byte_cnt + 2'd1;
          end
          LDR_WRITE: begin
            r_addr  <= next_word_addr(r_addr);
            r_words <= r_words + 16'd1;
            if (w_next == LDR_IDLE) r_busy <= 1'b0;
          end
          LDR_CHK: if (w_next == LDR_IDLE) begin
            r_busy <= 1'b0;
            if (r_count == 16'd0) r_sys_reset <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  assign busy_o      = r_busy;
  assign sys_reset_o = r_sys_reset;
  assign error_o     = r_error;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_uart_mem_loader.sv
// Randomized frame bench for uart_mem_loader: a frame model predicts word writes into exp_q,
// a negedge monitor pops and compares every bus strobe.
module tb_uart_mem_loader;
  import uart_mem_loader_pkg::*;

  localparam int CPB = 8;
  localparam int TO  = 1000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        rx_i;
  logic        mem_operation_enable_o;
  logic [3:0]  mem_write_enable_o;
  logic [31:0] mem_address_o;
  logic [31:0] mem_data_o;
  logic        busy_o;
  logic        sys_reset_o;
  logic        error_o;
  logic [2:0]  dbg_state_o;

  uart_mem_loader #(.CLKS_PER_BIT(CPB), .TIMEOUT_CYCLES(TO), .HOLD_AT_RESET(1'b1)) dut (
    .clk                   (clk),
    .reset_n               (reset_n),
    .rx_i                  (rx_i),
    .mem_operation_enable_o(mem_operation_enable_o),
    .mem_write_enable_o    (mem_write_enable_o),
    .mem_address_o         (mem_address_o),
    .mem_data_o            (mem_data_o),
    .busy_o                (busy_o),
    .sys_reset_o           (sys_reset_o),
    .error_o               (error_o),
    .dbg_state_o           (dbg_state_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [63:0] exp_q[$];
  logic [31:0] frame_words[$];
  logic [7:0]  fb[$];
  logic [7:0]  part_q[$];
  logic        exp_sys_reset;
  logic        busy_seen;
  logic        post_strobe;
  logic [63:0] mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    rx_i = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      repeat (CPB) @(posedge clk);
    end
    rx_i = stop_ok;
    repeat (CPB) @(posedge clk);
    rx_i = 1'b1;
    repeat (2 * CPB) @(posedge clk);
  endtask

  // Reference model: serialises a frame into fb and predicts the resulting writes.
  task automatic build_frame(input logic [31:0] addr);
    logic [15:0] cnt;
    logic [31:0] a;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] sum;
`endif
    fb.delete();
    fb.push_back(8'hA5);
    for (int i = 0; i < 4; i++) fb.push_back(addr[8*i +: 8]);
    cnt = 16'(frame_words.size());
    fb.push_back(cnt[7:0]);
    fb.push_back(cnt[15:8]);
    foreach (frame_words[w]) for (int i = 0; i < 4; i++) fb.push_back(frame_words[w][8*i +: 8]);
`ifdef LOADER_CHECKSUM_EN
    sum = 8'd0;
    for (int i = 1; i < fb.size(); i++) sum = sum + fb[i];
    fb.push_back(8'd0 - sum);
`endif
    a = addr & 32'hFFFF_FFFC;
    foreach (frame_words[w]) begin
      exp_q.push_back({a, frame_words[w]});
      a = a + 32'd4;
    end
    exp_sys_reset = (cnt != 16'd0);
  endtask

  task automatic send_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) send_byte(fb[i], 1'b1);
  endtask

  task automatic send_part();
    foreach (part_q[i]) send_byte(part_q[i], 1'b1);
  endtask

  task automatic frame_done_checks(input string name);
    @(negedge clk);
    check({name, "_busy"}, 32'(busy_o), 32'd0);
    check({name, "_error"}, 32'(error_o), 32'd0);
    check({name, "_sys_reset"}, 32'(sys_reset_o), 32'(exp_sys_reset));
    check({name, "_state"}, 32'(dbg_state_o), 32'(LDR_IDLE));
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (reset_n) begin
      if (busy_o) busy_seen = 1'b1;
      if (mem_operation_enable_o) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_write: addr 0x%08h data 0x%08h, expected no write", mem_address_o, mem_data_o);
        end else begin
          mon_e = exp_q.pop_front();
          check("write_addr", mem_address_o, mon_e[63:32]);
          check("write_data", mem_data_o, mon_e[31:0]);
          check("write_we", {28'd0, mem_write_enable_o}, 32'hF);
          check("write_busy", 32'(busy_o), 32'd1);
          check("write_sys_reset", 32'(sys_reset_o), 32'd1);
        end
        post_strobe = 1'b1;
      end else if (post_strobe) begin
        post_strobe = 1'b0;
        check("after_write_we", {28'd0, mem_write_enable_o}, 32'd0);
        check("after_write_addr", mem_address_o, 32'd0);
        check("after_write_data", mem_data_o, 32'd0);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] junk;
    rx_i          = 1'b1;
    reset_n       = 1'b0;
    exp_sys_reset = 1'b1;
    busy_seen     = 1'b0;
    post_strobe   = 1'b0;
    repeat (5) @(posedge clk);
    reset_n = 1'b1;

    // Quiet after reset: core held, bus idle.
    repeat (300) @(negedge clk);
    check("rst_sys_reset", 32'(sys_reset_o), 32'd1);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_error", 32'(error_o), 32'd0);
    check("rst_mem_en", 32'(mem_operation_enable_o), 32'd0);
    check("rst_we", {28'd0, mem_write_enable_o}, 32'd0);
    check("rst_addr", mem_address_o, 32'd0);
    check("rst_data", mem_data_o, 32'd0);
    check("rst_state", 32'(dbg_state_o), 32'(LDR_IDLE));
    check("rst_no_busy", 32'(busy_seen), 32'd0);

    // Directed two-word frame; busy must rise right after the count bytes.
    frame_words = '{32'hDEAD_BEEF, 32'h1234_5678};
    build_frame(32'h0);
    send_range(0, 6);
    @(negedge clk);
    check("cnt_busy", 32'(busy_o), 32'd1);
    check("cnt_sys_reset", 32'(sys_reset_o), 32'd1);
    send_range(7, fb.size() - 1);
    frame_done_checks("frame2");

    // Address wrap at the top of the space.
    frame_words = '{$urandom, $urandom};
    build_frame(32'hFFFF_FFFE);
    send_range(0, fb.size() - 1);
    frame_done_checks("wrap");

    // Random non-sync bytes in IDLE followed by random frames.
    for (int k = 0; k < 8; k++) begin
      junk = 8'($urandom_range(0, 255));
      if (junk == 8'hA5) junk = 8'h5A;
      send_byte(junk, 1'b1);
      frame_words.delete();
      for (int w = 0; w < $urandom_range(1, 4); w++) frame_words.push_back($urandom);
      build_frame($urandom);
      send_range(0, fb.size() - 1);
      frame_done_checks("rand");
    end

    // Bad stop bit inside a frame.
    send_byte(8'hA5, 1'b1);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b0);
    repeat (20 * CPB) @(posedge clk);
    @(negedge clk);
    check("ferr_error", 32'(error_o), 32'd1);
    check("ferr_busy", 32'(busy_o), 32'd0);
    check("ferr_state", 32'(dbg_state_o), 32'(LDR_IDLE));
    check("ferr_sys_reset", 32'(sys_reset_o), 32'(exp_sys_reset));

    // Stall after three data bytes.
    part_q = '{8'hA5, 8'h00, 8'h01, 8'h00, 8'h00, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33};
    send_part();
    @(negedge clk);
    check("stall_error_cleared", 32'(error_o), 32'd0);
    check("stall_busy", 32'(busy_o), 32'd1);
    repeat (TO + 100) @(posedge clk);
    @(negedge clk);
    check("timeout_error", 32'(error_o), 32'd1);
    check("timeout_busy", 32'(busy_o), 32'd0);
    check("timeout_state", 32'(dbg_state_o), 32'(LDR_IDLE));
    check("timeout_sys_reset", 32'(sys_reset_o), 32'd1);

    // Recovery: error clears at the sync byte.
    frame_words = '{$urandom};
    build_frame(32'h0000_2000);
    send_range(0, 0);
    @(negedge clk);
    check("sync_clears_error", 32'(error_o), 32'd0);
    send_range(1, fb.size() - 1);
    frame_done_checks("recover");

`ifdef LOADER_CHECKSUM_EN
    part_q = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
    send_part();
    @(negedge clk);
    check("badsum_error", 32'(error_o), 32'd1);
    check("badsum_sys_reset", 32'(sys_reset_o), 32'd1);
`endif

    // Boot frame: never busy, core released only by the final byte.
    frame_words.delete();
    build_frame(32'h0);
    busy_seen = 1'b0;
    send_range(0, fb.size() - 2);
    @(negedge clk);
    check("boot_held_before_last", 32'(sys_reset_o), 32'd1);
    send_range(fb.size() - 1, fb.size() - 1);
    frame_done_checks("boot");
    check("boot_never_busy", 32'(busy_seen), 32'd0);

    // A data frame re-asserts core reset.
    frame_words = '{$urandom};
    build_frame($urandom);
    send_range(0, fb.size() - 1);
    frame_done_checks("reload");

    // Reset mid-word: partial data discarded, then a clean frame.
    part_q = '{8'hA5, 8'h40, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h11, 8'h22};
    send_part();
    @(negedge clk);
    check("midrst_busy_before", 32'(busy_o), 32'd1);
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("midrst_busy", 32'(busy_o), 32'd0);
    check("midrst_error", 32'(error_o), 32'd0);
    check("midrst_sys_reset", 32'(sys_reset_o), 32'd1);
    check("midrst_state", 32'(dbg_state_o), 32'(LDR_IDLE));
    frame_words = '{$urandom, $urandom, $urandom};
    build_frame(32'h0000_0040);
    send_range(0, fb.size() - 1);
    frame_done_checks("after_rst");

    repeat (20) @(posedge clk);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
